// File: rtl/key_sched_ctrl.sv
`default_nettype none
// ============================================================================
// key_sched_ctrl : sequences the 64-bit key schedule and streams round keys.
// Optional KSCHED_CACHE_EN adds a round-key cache with forward/reverse replay.
// Revision: 1.0
// ============================================================================
module key_sched_ctrl #(
    parameter int NUM_ROUNDS = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] key_in,
    output logic [63:0] exp_key,
    output logic [5:0]  exp_rc,
    input  logic [63:0] exp_key_next,
    output logic [63:0] rk_data,
    output logic [5:0]  rk_idx,
    output logic        rk_valid,
    input  logic        rk_ready,
    output logic        busy,
    output logic        done
`ifdef KSCHED_CACHE_EN
    ,
    input  logic        replay,
    input  logic        reverse
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_EMIT   = 3'd2,
        ST_DONE   = 3'd3,
        ST_REPLAY = 3'd4
    } state_t;

    localparam logic [5:0] c_last_idx = 6'(NUM_ROUNDS);

    state_t      r_state;
    logic [63:0] r_key;
    logic [4:0]  r_rc;
    logic [5:0]  r_idx;
    logic [63:0] r_rk_data;
    logic        r_rk_valid;
    logic        r_busy;
    logic        r_done;

    logic        w_accept;
    logic [4:0]  w_rc_next;

    assign w_accept  = r_rk_valid & rk_ready;
    assign w_rc_next = {r_rc[3:0], r_rc[4] ^ r_rc[2]};

    assign exp_key  = r_key;
    assign exp_rc   = {1'b0, r_rc};
    assign rk_data  = r_rk_data;
    assign rk_idx   = r_idx;
    assign rk_valid = r_rk_valid;
    assign busy     = r_busy;
    assign done     = r_done;

`ifdef KSCHED_CACHE_EN
    localparam int c_aw = $clog2(NUM_ROUNDS + 1);

    logic [63:0] r_cache [0:NUM_ROUNDS];
    logic        r_cache_valid;
    logic        r_reverse;
    logic [5:0]  w_replay_first;
    logic [5:0]  w_replay_next;
    logic        w_replay_last;

    assign w_replay_first = reverse ? c_last_idx : 6'd0;
    assign w_replay_next  = r_reverse ? (r_idx - 6'd1) : (r_idx + 6'd1);
    assign w_replay_last  = r_reverse ? (r_idx == 6'd0) : (r_idx == c_last_idx);

    // Cache holds data only; validity is tracked by r_cache_valid, so no reset needed.
    always_ff @(posedge clk) begin
        if (r_state == ST_EMIT && w_accept) begin
            r_cache[r_idx[c_aw-1:0]] <= r_rk_data;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_key      <= 64'd0;
            r_rc       <= 5'h01;
            r_idx      <= 6'd0;
            r_rk_data  <= 64'd0;
            r_rk_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef KSCHED_CACHE_EN
            r_cache_valid <= 1'b0;
            r_reverse     <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_key   <= key_in;
                        r_rc    <= 5'h01;
                        r_idx   <= 6'd0;
                        r_busy  <= 1'b1;
                        r_state <= ST_LOAD;
`ifdef KSCHED_CACHE_EN
                        r_cache_valid <= 1'b0;
                    end else if (r_state == ST_IDLE && replay && r_cache_valid) begin
                        r_reverse  <= reverse;
                        r_idx      <= w_replay_first;
                        r_rk_data  <= r_cache[w_replay_first[c_aw-1:0]];
                        r_rk_valid <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_REPLAY;
`endif
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end

                // One settle cycle so exp_key_next reflects the freshly loaded key.
                ST_LOAD: begin
                    r_rk_data  <= r_key;
                    r_rk_valid <= 1'b1;
                    r_state    <= ST_EMIT;
                end

                ST_EMIT: begin
                    if (w_accept) begin
                        if (r_idx == c_last_idx) begin
                            r_rk_valid <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= ST_DONE;
`ifdef KSCHED_CACHE_EN
                            r_cache_valid <= 1'b1;
`endif
                        end else begin
                            r_key     <= exp_key_next;
                            r_rk_data <= exp_key_next;
                            r_rc      <= w_rc_next;
                            r_idx     <= r_idx + 6'd1;
                        end
                    end
                end

`ifdef KSCHED_CACHE_EN
                ST_REPLAY: begin
                    if (w_accept) begin
                        if (w_replay_last) begin
                            r_rk_valid <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= ST_DONE;
                        end else begin
                            r_idx     <= w_replay_next;
                            r_rk_data <= r_cache[w_replay_next[c_aw-1:0]];
                        end
                    end
                end
`endif

                default: begin
                    r_rk_valid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
